// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : display_pkg
// Description : Shared constants, state encoding and helpers for the
//               multiplexed 7-segment display scan logic.
// Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

  localparam int unsigned N_DIGITOS   = 4;
  localparam int unsigned BCD_W       = 4;
  localparam logic [3:0]  ANODOS_OFF  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } estado_t;

  // Active-low anode pattern that lights only digit idx.
  function automatic logic [3:0] anodo_activo(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  // BCD nibble idx of a 4-digit value.
  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] idx);
    return v[{idx, 2'b00} +: 4];
  endfunction

  // A digit is significant when it is digit 0 or any nibble from idx upward is non-zero.
  function automatic logic digito_visible(input logic [15:0] v, input logic [1:0] idx);
    return (idx == 2'd0) || ((v >> {idx, 2'b00}) != 16'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/contador_intervalo.sv
`default_nettype none
// ============================================================================
// Module      : contador_intervalo
// Description : Loadable down-counter that stops at zero; done is high while
//               the count is zero, i.e. on the last cycle of an interval.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_intervalo #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] r_count;

  // Load takes priority; otherwise count down and hold at zero.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/barrido_display.sv
`default_nettype none
// ============================================================================
// Module      : barrido_display
// Description : Scan controller for a 4-digit multiplexed 7-segment display.
//               A staging register captures new values at any time; they move
//               to the shadow register only at a frame boundary (or while
//               idle) so a frame never mixes two values. Each digit is
//               preceded by a blanking interval to hide decoder latency.
//               Optional macro BARRIDO_LEADING_ZERO_BLANK_EN keeps leading
//               zero digits dark (digit 0 always lit).
// Revision    : 1.0 - initial release
// ============================================================================
module barrido_display
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE     = 25000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] valor,
  input  logic        cargar,
  output logic [3:0]  numero,
  output logic [3:0]  anodos,
  output logic        actualizado
);

  localparam int unsigned c_MAX   = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned c_CNT_W = $clog2(c_MAX + 1);
  localparam logic [c_CNT_W-1:0] c_SHOW_LOAD  = c_CNT_W'(PRESCALE - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_LOAD = c_CNT_W'(BLANK_CYCLES - 1);

  estado_t             r_state;
  estado_t             w_next_state;
  logic [1:0]          r_index;
  logic [1:0]          w_next_index;
  logic [15:0]         r_staging;
  logic [15:0]         r_shadow;
  logic [15:0]         w_shadow_next;
  logic                r_pending;
  logic                w_transfer;
  logic                w_done;
  logic                w_load;
  logic [c_CNT_W-1:0]  w_load_value;
  logic [3:0]          w_anodos_next;
  logic [3:0]          w_numero_next;
  logic [3:0]          r_numero;
  logic [3:0]          r_anodos;
  logic                r_actualizado;

  // Interval timer shared by the blanking and lit phases.
  contador_intervalo #(
    .WIDTH (c_CNT_W)
  ) u_contador (
    .CLK        (CLK),
    .reset      (reset),
    .load       (w_load),
    .load_value (w_load_value),
    .done       (w_done)
  );

  // A waiting value moves to the shadow at the end of digit 3 or whenever idle.
  assign w_transfer    = r_pending &&
                         ((r_state == IDLE) ||
                          ((r_state == SHOW) && (r_index == 2'd3) && w_done));
  assign w_shadow_next = w_transfer ? r_staging : r_shadow;

  // State and digit index register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_index <= 2'd0;
    end else begin
      r_state <= w_next_state;
      r_index <= w_next_index;
    end
  end

  // Next-state logic; dropping enable forces IDLE from any state.
  always_comb begin
    w_next_state = r_state;
    w_next_index = r_index;
    if (!enable) begin
      w_next_state = IDLE;
      w_next_index = 2'd0;
    end else begin
      case (r_state)
        IDLE:    begin
          w_next_state = BLANK;
          w_next_index = 2'd0;
        end
        BLANK:   if (w_done) w_next_state = SHOW;
        SHOW:    if (w_done) begin
          w_next_state = BLANK;
          w_next_index = r_index + 2'd1;
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Output and timer control, computed from the upcoming state so outputs register cleanly.
  always_comb begin
    w_anodos_next = ANODOS_OFF;
    w_numero_next = r_numero;
    w_load        = (w_next_state != r_state) || (r_state == IDLE);
    w_load_value  = '0;
    if (w_next_state == SHOW) begin
`ifdef BARRIDO_LEADING_ZERO_BLANK_EN
      if (digito_visible(w_shadow_next, w_next_index)) begin
        w_anodos_next = anodo_activo(w_next_index);
      end
`else
      w_anodos_next = anodo_activo(w_next_index);
`endif
      w_load_value  = c_SHOW_LOAD;
    end else if (w_next_state == BLANK) begin
      w_load_value  = c_BLANK_LOAD;
    end
    // The digit code is presented at the start of blanking, giving the decoder time to settle.
    if ((w_next_state == BLANK) && (r_state != BLANK)) begin
      w_numero_next = nibble(w_shadow_next, w_next_index);
    end
  end

  // Load path, shadow transfer and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_staging     <= 16'd0;
      r_shadow      <= 16'd0;
      r_pending     <= 1'b0;
      r_numero      <= 4'd0;
      r_anodos      <= ANODOS_OFF;
      r_actualizado <= 1'b0;
    end else begin
      r_shadow      <= w_shadow_next;
      r_actualizado <= w_transfer;
      if (cargar) begin
        r_staging <= valor;
        r_pending <= 1'b1;
      end else if (w_transfer) begin
        r_pending <= 1'b0;
      end
      r_numero      <= w_numero_next;
      r_anodos      <= w_anodos_next;
    end
  end

  assign numero      = r_numero;
  assign anodos      = r_anodos;
  assign actualizado = r_actualizado;

endmodule
`default_nettype wire

// File: tb/tb_barrido_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrido_display
// Description : Self-checking bench for barrido_display (PRESCALE=8,
//               BLANK_CYCLES=2). A cycle-count reference model predicts the
//               anodes, digit code and update pulse after every clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrido_display;

  localparam int unsigned c_PRESCALE = 8;
  localparam int unsigned c_BLANK    = 2;
  localparam int unsigned c_SLOT     = c_PRESCALE + c_BLANK;
  localparam int unsigned c_FRAME    = 4 * c_SLOT;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] valor = 16'd0;
  logic        cargar = 1'b0;
  logic [3:0]  numero;
  logic [3:0]  anodos;
  logic        actualizado;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: scan position is a plain count of edges since scanning began.
  bit          m_active;
  int          m_k;
  logic [15:0] m_staging, m_shadow;
  bit          m_pending;
  logic [3:0]  m_numero;
  bit          m_act;

  barrido_display #(
    .PRESCALE     (c_PRESCALE),
    .BLANK_CYCLES (c_BLANK)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .enable      (enable),
    .valor       (valor),
    .cargar      (cargar),
    .numero      (numero),
    .anodos      (anodos),
    .actualizado (actualizado)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active  = 0;
    m_k       = 0;
    m_staging = 16'd0;
    m_shadow  = 16'd0;
    m_pending = 0;
    m_numero  = 4'd0;
    m_act     = 0;
  endtask

  task automatic model_edge(input bit en, input bit ld, input logic [15:0] v);
    bit tr;
    int dig;
    tr = m_pending && (!m_active || (((m_k + 1) % c_FRAME) == 0));
    if (tr) m_shadow = m_staging;
    m_act = tr;
    if (ld) begin
      m_staging = v;
      m_pending = 1;
    end else if (tr) begin
      m_pending = 0;
    end
    if (!en) begin
      m_active = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_k = 0;
    end else begin
      m_k++;
    end
    if (m_active) begin
      dig = (m_k / c_SLOT) % 4;
      m_numero = 4'((m_shadow >> (4 * dig)) & 16'h000F);
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_an;
    int dig;
    exp_an = 4'b1111;
    if (m_active && ((m_k % c_SLOT) >= c_BLANK)) begin
      dig = (m_k / c_SLOT) % 4;
`ifdef BARRIDO_LEADING_ZERO_BLANK_EN
      if (dig == 0 || (m_shadow >> (4 * dig)) != 16'd0) exp_an = ~(4'b0001 << dig);
`else
      exp_an = ~(4'b0001 << dig);
`endif
    end
    chk("anodos", {12'd0, anodos}, {12'd0, exp_an});
    chk("numero", {12'd0, numero}, {12'd0, m_numero});
    chk("actualizado", {15'd0, actualizado}, {15'd0, m_act});
  endtask

  // One clock cycle with the given inputs, then model update and output check.
  task automatic cyc(input bit en, input bit ld, input logic [15:0] v);
    enable = en;
    cargar = ld;
    valor  = v;
    @(posedge CLK);
    model_edge(en, ld, v);
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 16'd0);
  endtask

  // Scan until the post-edge position within the frame equals pos (bounded).
  task automatic run_to(input int pos);
    int i;
    for (i = 0; i < 4 * c_FRAME; i++) begin
      if (m_active && (m_k % c_FRAME) == pos) break;
      cyc(1'b1, 1'b0, 16'd0);
    end
    chk("run_to_timeout", 16'(i < 4 * c_FRAME), 16'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_anodos"}, {12'd0, anodos}, 16'h000F);
    chk({tag, "_numero"}, {12'd0, numero}, 16'h0000);
    chk({tag, "_actualizado"}, {15'd0, actualizado}, 16'h0000);
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1 check_reset_values("reset");
    @(posedge CLK);
    #3 reset = 1'b0;

    // Shadow zero: blank, digit 0, then 1101, 1011, 0111, frame repeat.
    run(2 * c_FRAME + 5);

    // Mid-frame load appears only after the boundary.
    run_to(15);
    cyc(1'b1, 1'b1, 16'h1234);
    run(2 * c_FRAME);

    // Load on the boundary cycle while a value is still pending.
    run_to(20);
    cyc(1'b1, 1'b1, 16'h1234);
    run_to(c_FRAME - 1);
    cyc(1'b1, 1'b1, 16'h5678);
    run(2 * c_FRAME + 3);

    // Randomised loads, including non-BCD nibbles and occasional enable drops.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0), 16'($urandom));
    end

    // Drop enable during digit 2, load while idle, then resume at digit 0.
    run_to(2 * c_SLOT + c_BLANK + 3);
    cyc(1'b0, 1'b0, 16'd0);
    cyc(1'b0, 1'b1, 16'h9A0B);
    cyc(1'b0, 1'b0, 16'd0);
    run(c_FRAME + 4);

    // Asynchronous reset during blanking of digit 1.
    run_to(c_SLOT);
    #2 reset = 1'b1;
    #1 check_reset_values("async_reset");
    model_reset();
    @(posedge CLK);
    #1 check_reset_values("reset_hold");
    #3 reset = 1'b0;
    run(c_FRAME + 2);

    // Leading-zero patterns.
    cyc(1'b0, 1'b1, 16'h0070);
    cyc(1'b0, 1'b0, 16'd0);
    run(c_FRAME + 5);
    cyc(1'b0, 1'b1, 16'h0000);
    cyc(1'b0, 1'b0, 16'd0);
    run(c_FRAME + 5);
    cyc(1'b0, 1'b1, 16'h0305);
    cyc(1'b0, 1'b0, 16'd0);
    run(c_FRAME + 5);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
